// File: rtl/deserializer_out.sv
`default_nettype none
// ============================================================================
//  Module   : deserializer_out
//  Purpose  : Receive side of the 9-bit serial link. Shifts in one bit per
//             clock, aligns to the K-comma word {1'b1, COMMA}, and rebuilds
//             each comma-led frame of three data words into a 27-bit word.
//             Reports lock, framing errors and a saturating error count.
//  Ports    :
//    clk_i        in   1          system clock, one serial bit per edge
//    rst_i        in   1          asynchronous active-high reset
//    data_i       in   1          serial line, MSB (K bit) first
//    data_o       out  27         {word3, word2, word1}
//    valid_o      out  1          one-cycle strobe, data_o updated with it
//    lock_o       out  1          high while word alignment is held
//    frame_err_o  out  1          one-cycle strobe on a framing violation
//    err_cnt_o    out  ERR_CNT_W  saturating count of frame_err_o pulses
//  Revision : 1.0 - initial release
// ============================================================================
module deserializer_out #(
    parameter logic [7:0] COMMA       = 8'h3C,
    parameter int         LOSS_THRESH = 4,
    parameter int         ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_i,
    output logic [26:0]          data_o,
    output logic                 valid_o,
    output logic                 lock_o,
    output logic                 frame_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [8:0] c_COMMA_WORD = {1'b1, COMMA};
    localparam logic [3:0] c_LOSS       = LOSS_THRESH[3:0];
    localparam logic [3:0] c_LAST_BIT   = 4'd8;
    localparam logic [ERR_CNT_W-1:0] c_ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [8:0]           sr_q,        sr_d;
    logic [3:0]           bitcnt_q,    bitcnt_d;
    logic [1:0]           slot_q,      slot_d;
    logic [3:0]           badcnt_q,    badcnt_d;
    logic                 armed_q,     armed_d;
    logic [8:0]           word1_q,     word1_d;
    logic [8:0]           word2_q,     word2_d;
    logic [26:0]          data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 ferr_q,      ferr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

    // Candidate word includes the bit being sampled now, so a word is
    // acted on at the very edge that captures its last bit.
    logic [8:0] w;
    assign w = {sr_q[7:0], data_i};

    always_comb begin
        state_d   = state_q;
        sr_d      = w;
        bitcnt_d  = bitcnt_q;
        slot_d    = slot_q;
        badcnt_d  = badcnt_q;
        armed_d   = armed_q;
        word1_d   = word1_q;
        word2_d   = word2_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (w == c_COMMA_WORD) begin
                    state_d  = ST_LOCKED;
                    bitcnt_d = 4'd0;
                    slot_d   = 2'd0;
                    badcnt_d = 4'd0;
                    // The alignment comma also opens the first frame.
                    armed_d  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (bitcnt_q == c_LAST_BIT) begin
                    bitcnt_d = 4'd0;
                    if (w == c_COMMA_WORD) begin
                        // A comma inside a frame aborts the partial frame.
                        if (slot_q != 2'd0) begin
                            ferr_d = 1'b1;
                        end
                        slot_d   = 2'd0;
                        badcnt_d = 4'd0;
                        armed_d  = 1'b1;
                    end else if (!w[8]) begin
                        if (slot_q == 2'd0 && !armed_q) begin
                            // Data with no leading comma: drop it.
                            ferr_d   = 1'b1;
                            badcnt_d = badcnt_q + 4'd1;
                        end else if (slot_q == 2'd0) begin
                            word1_d = w;
                            slot_d  = 2'd1;
                        end else if (slot_q == 2'd1) begin
                            word2_d = w;
                            slot_d  = 2'd2;
                        end else begin
                            data_d   = {w, word2_q, word1_q};
                            valid_d  = 1'b1;
                            slot_d   = 2'd0;
                            badcnt_d = 4'd0;
                            armed_d  = 1'b0;
                        end
                    end else begin
                        // Any K word other than the comma.
                        ferr_d   = 1'b1;
                        slot_d   = 2'd0;
                        armed_d  = 1'b0;
                        badcnt_d = badcnt_q + 4'd1;
                    end

                    if (badcnt_d >= c_LOSS) begin
                        state_d = ST_HUNT;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (ferr_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + c_ERR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_HUNT;
            sr_q      <= '0;
            bitcnt_q  <= '0;
            slot_q    <= '0;
            badcnt_q  <= '0;
            armed_q   <= 1'b0;
            word1_q   <= '0;
            word2_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bitcnt_q  <= bitcnt_d;
            slot_q    <= slot_d;
            badcnt_q  <= badcnt_d;
            armed_q   <= armed_d;
            word1_q   <= word1_d;
            word2_q   <= word2_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign lock_o      = (state_q == ST_LOCKED);
    assign frame_err_o = ferr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deserializer_out
//  Purpose  : Directed self-checking bench for deserializer_out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer_out;

    localparam logic [8:0] c_COMMA = 9'h13C;
    localparam logic [8:0] c_KBAD  = 9'h1F7;

    logic        clk;
    logic        rst;
    logic        data_i;
    logic [26:0] data_o;
    logic        valid_o;
    logic        lock_o;
    logic        frame_err_o;
    logic [7:0]  err_cnt_o;

    int n_cmp;
    int n_bad;

    // Observations accumulated while bits are shifted in.
    int          bitnum;
    int          valid_cnt;
    int          valid_bit;
    int          ferr_cnt;
    int          both_cnt;
    logic [26:0] last_data;

    deserializer_out #(
        .COMMA       (8'h3C),
        .LOSS_THRESH (4),
        .ERR_CNT_W   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .lock_o      (lock_o),
        .frame_err_o (frame_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_obs();
        bitnum    = 0;
        valid_cnt = 0;
        valid_bit = -1;
        ferr_cnt  = 0;
        both_cnt  = 0;
        last_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        data_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_i = b;
        @(posedge clk);
        #1;
        bitnum++;
        if (valid_o === 1'b1) begin
            valid_cnt++;
            valid_bit = bitnum;
            last_data = data_o;
        end
        if (frame_err_o === 1'b1) ferr_cnt++;
        if (valid_o === 1'b1 && frame_err_o === 1'b1) both_cnt++;
    endtask

    task automatic send_word(input logic [8:0] wd);
        for (int i = 8; i >= 0; i--) send_bit(wd[i]);
    endtask

    task automatic send_frame(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        send_word(c_COMMA);
        send_word(a);
        send_word(b);
        send_word(c);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (data_o !== 27'h0)     begin n_bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_cmp++; if (valid_o !== 1'b0)     begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (lock_o !== 1'b0)      begin n_bad++; $display("FAIL reset_lock: got %b want 0", lock_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_cmp++; if (err_cnt_o !== 8'h0)   begin n_bad++; $display("FAIL reset_errcnt: got %h want 0", err_cnt_o); end
    endtask

    task automatic test_lock();
        logic [8:0] cw;
        cw = c_COMMA;
        do_reset();
        for (int i = 8; i >= 1; i--) send_bit(cw[i]);
        n_cmp++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b want 0", lock_o); end
        send_bit(cw[0]);
        n_cmp++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL lock_on_9th: got %b want 1", lock_o); end
        for (int k = 0; k < 4; k++) send_word(c_COMMA);
        n_cmp++; if (lock_o !== 1'b1)  begin n_bad++; $display("FAIL lock_hold: got %b want 1", lock_o); end
        n_cmp++; if (valid_cnt !== 0)  begin n_bad++; $display("FAIL lock_novalid: got %0d want 0", valid_cnt); end
        n_cmp++; if (err_cnt_o !== 8'h0) begin n_bad++; $display("FAIL lock_errcnt: got %h want 0", err_cnt_o); end
    endtask

    task automatic test_frame();
        do_reset();
        send_frame(9'h0A5, 9'h05A, 9'h0FF);
        send_word(c_COMMA);
        n_cmp++; if (valid_cnt !== 1)   begin n_bad++; $display("FAIL frame_count: got %0d want 1", valid_cnt); end
        n_cmp++; if (valid_bit !== 36)  begin n_bad++; $display("FAIL frame_latency: got bit %0d want 36", valid_bit); end
        n_cmp++; if (last_data !== 27'h3FCB4A5) begin n_bad++; $display("FAIL frame_data: got %h want 3fcb4a5", last_data); end
        n_cmp++; if (data_o !== 27'h3FCB4A5)    begin n_bad++; $display("FAIL frame_hold: got %h want 3fcb4a5", data_o); end
        n_cmp++; if (ferr_cnt !== 0)    begin n_bad++; $display("FAIL frame_noerr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(c_COMMA);
        send_word(c_COMMA);
        send_frame(9'h0A5, 9'h05A, 9'h0FF);
        for (int k = 0; k < 5; k++) send_word(c_COMMA);
        send_frame(9'h001, 9'h002, 9'h003);
        send_word(c_COMMA);
        n_cmp++; if (valid_cnt !== 2)  begin n_bad++; $display("FAIL b2b_count: got %0d want 2", valid_cnt); end
        n_cmp++; if (last_data !== 27'h00C0401) begin n_bad++; $display("FAIL b2b_data: got %h want 00c0401", last_data); end
        n_cmp++; if (ferr_cnt !== 0)   begin n_bad++; $display("FAIL b2b_noerr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_midframe_comma();
        do_reset();
        send_word(c_COMMA);
        send_word(9'h011);
        send_frame(9'h010, 9'h020, 9'h030);
        send_word(c_COMMA);
        n_cmp++; if (ferr_cnt !== 1)     begin n_bad++; $display("FAIL mid_ferr: got %0d want 1", ferr_cnt); end
        n_cmp++; if (err_cnt_o !== 8'd1) begin n_bad++; $display("FAIL mid_errcnt: got %0d want 1", err_cnt_o); end
        n_cmp++; if (valid_cnt !== 1)    begin n_bad++; $display("FAIL mid_valid: got %0d want 1", valid_cnt); end
        n_cmp++; if (last_data !== 27'h0C04010) begin n_bad++; $display("FAIL mid_data: got %h want 0c04010", last_data); end
    endtask

    task automatic test_unframed_data();
        // A completed frame followed by data without a comma is dropped.
        do_reset();
        send_frame(9'h001, 9'h002, 9'h003);
        send_word(9'h044);
        n_cmp++; if (ferr_cnt !== 1)     begin n_bad++; $display("FAIL unframed_ferr: got %0d want 1", ferr_cnt); end
        n_cmp++; if (err_cnt_o !== 8'd1) begin n_bad++; $display("FAIL unframed_errcnt: got %0d want 1", err_cnt_o); end
        n_cmp++; if (lock_o !== 1'b1)    begin n_bad++; $display("FAIL unframed_lock: got %b want 1", lock_o); end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_word(c_COMMA);
        for (int k = 0; k < 3; k++) send_word(c_KBAD);
        n_cmp++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL loss_hold3: got %b want 1", lock_o); end
        send_word(c_KBAD);
        n_cmp++; if (lock_o !== 1'b0)    begin n_bad++; $display("FAIL loss_drop: got %b want 0", lock_o); end
        n_cmp++; if (ferr_cnt !== 4)     begin n_bad++; $display("FAIL loss_ferr: got %0d want 4", ferr_cnt); end
        n_cmp++; if (err_cnt_o !== 8'd4) begin n_bad++; $display("FAIL loss_errcnt: got %0d want 4", err_cnt_o); end
        send_word(c_COMMA);
        n_cmp++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL loss_relock: got %b want 1", lock_o); end
        n_cmp++; if (both_cnt !== 0)  begin n_bad++; $display("FAIL loss_overlap: got %0d want 0", both_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_frame(9'h0A5, 9'h05A, 9'h0FF);
        send_word(c_COMMA);
        send_word(9'h011);
        send_word(9'h022);
        // Assert reset between clock edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (data_o !== 27'h0) begin n_bad++; $display("FAIL areset_data: got %h want 0", data_o); end
        n_cmp++; if (lock_o !== 1'b0)  begin n_bad++; $display("FAIL areset_lock: got %b want 0", lock_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", valid_o); end
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        // Partial frame must not complete from leftover slot state.
        send_word(9'h033);
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL areset_stale: got %0d want 0", valid_cnt); end
        send_frame(9'h055, 9'h0AA, 9'h0F0);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL areset_count: got %0d want 1", valid_cnt); end
        n_cmp++; if (last_data !== 27'h3C15455) begin n_bad++; $display("FAIL areset_data2: got %h want 3c15455", last_data); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        data_i = 1'b0;
        clear_obs();
        test_reset();
        test_lock();
        test_frame();
        test_back_to_back();
        test_midframe_comma();
        test_unframed_data();
        test_loss_of_lock();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deserializer_out.md
Name: deserializer_out

Overview:
- Receive-side counterpart of the 9-bit serial link transmitter.
- Consumes the serial bitstream one bit per clock and aligns to the K-comma word {1'b1, 8'h3C}.
- Reassembles each frame of one comma plus three data words into a 27-bit word, presented with a one-cycle valid strobe.
- Reports lock status, framing errors and a saturating error count to the link controller.

Parameters:
- COMMA, 8'h3C, payload byte of the K-comma (with K=1 forms alignment word 9'h13C).
- LOSS_THRESH, 4, consecutive bad words in LOCKED that force return to HUNT (range 1..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  system clock, one serial bit sampled per rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  1  serial line. Each 9-bit word is sent MSB first: K bit (bit 8) first, then bits 7..0.
- data_o  output  27  frame payload {word3, word2, word1}: word1 in [8:0], word2 in [17:9], word3 in [26:18]. K bit of each word is included (0 for data).
- valid_o  output  1  one-cycle strobe; data_o is updated in the same cycle.
- lock_o  output  1  high while in LOCKED.
- frame_err_o  output  1  one-cycle strobe on any framing violation.
- err_cnt_o  output  ERR_CNT_W  saturating count of frame_err_o pulses since reset.

Behaviour:
- Reset (async, rst_i=1):
  - Outputs: data_o=0, valid_o=0, lock_o=0, frame_err_o=0, err_cnt_o=0.
  - Internal: shift register=0, bit counter=0, slot=0, bad-word counter=0, state=HUNT.
  - Reset asserted mid-frame discards the partial frame; no valid_o is produced.
- Shift register and candidate word:
  - Shift register sr[8:0] updates every edge: sr <= {sr[7:0], data_i}.
  - Candidate word w = {sr[7:0], data_i} (combinational). All decisions use w, so a word is processed on the edge that samples its last bit.
- HUNT:
  - Every edge: if w == {1'b1, COMMA}, go to LOCKED with bitcnt=0, slot=0, badcnt=0.
  - Otherwise stay in HUNT. No valid_o and no frame_err_o are produced in HUNT.
- LOCKED:
  - bitcnt counts 0..8 and wraps; a word completes when bitcnt==8.
  - On word completion, classify w:
    - Comma (9'h13C):
      - If slot is 0: idle or frame start; slot stays 0.
      - If slot is 1 or 2: partial frame is discarded, frame_err_o pulses, slot=0.
      - badcnt=0 in both cases.
    - Data (w[8]==0):
      - Store w into the lane selected by slot, then slot++.
      - When slot==2 (third data word): data_o <= {w, word2, word1}, valid_o pulses the next cycle, slot=0, badcnt=0.
    - Data arriving at slot 0 with no preceding comma, after a completed frame: framing error. frame_err_o pulses, word is dropped, badcnt++.
    - K word other than the comma: frame_err_o pulses, slot=0, badcnt++.
  - Only the slot-0 data case and the non-comma K case increment badcnt.
  - Frame-start tracking: a comma sets an internal "armed" flag; completing a frame clears it. At slot 0, data is accepted only when armed.
  - When badcnt reaches LOSS_THRESH: go to HUNT and drop lock_o on the same edge.
- Latency: valid_o is high during the cycle right after the edge that samples the last bit (bit 0) of the third data word.
- Timing and overflow rules:
  - valid_o and frame_err_o never assert in the same cycle.
  - err_cnt_o saturates at all-ones and does not wrap.
  - data_o holds its value between valid_o strobes.

Test Plan:
- Reset then continuous commas (9'h13C repeated) -> lock_o=1 after the edge sampling the first comma's 9th bit. No valid_o, err_cnt_o=0.
- Comma, then words 9'h0A5, 9'h05A, 9'h0FF -> valid_o pulses exactly once, in the cycle after the 36th bit edge, with data_o=27'h3FCB4A5.
- Idle commas, frame, 5 idle commas, second frame 9'h001/9'h002/9'h003 -> two valid_o pulses; second data_o=27'h0C0401.
- Comma, 9'h011, then comma mid-frame, then a full frame -> one frame_err_o pulse, err_cnt_o=1, partial discarded. Next frame is delivered correctly.
- While locked, four consecutive K words 9'h1F7 -> four frame_err_o pulses, lock_o=0 after the fourth. Re-locks on the next comma.
- Assert rst_i asynchronously after word2 of a frame -> all outputs 0 immediately. Then send comma plus three data words -> correct valid_o/data_o with no stale lanes.
